key_conditioner: RTL
====================

Name: key_conditioner

Overview:
Input-side front end for the board push-buttons. It turns raw, bouncing, active-low KEY inputs into clean, clock-synchronous signals. For each key it provides a debounced level, a one-cycle press pulse and a one-cycle release pulse. These replace driving counters and FSMs directly from an inverted KEY line: downstream logic runs on the system clock and uses press_pulse as an enable.

Parameters:
N_KEYS, 2, number of independent key channels
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized cycles required to accept a level change (20 ms at 50 MHz); legal range >= 1
REPEAT_DELAY, 25000000, auto-repeat hold time before the first repeat pulse; used only with KEY_AUTOREPEAT_EN; >= 1
REPEAT_PERIOD, 5000000, auto-repeat interval between repeat pulses; used only with KEY_AUTOREPEAT_EN; >= 1

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
KEY  input  N_KEYS  raw board buttons, active-low (0 = pressed), asynchronous to clock
pressed  output  N_KEYS  debounced level per key, 1 = pressed
press_pulse  output  N_KEYS  one-cycle strobe per accepted press (plus repeats when enabled)
release_pulse  output  N_KEYS  one-cycle strobe per accepted release
any_press  output  1  OR of press_pulse, same cycle

Behaviour:
- Per key, a 2-flop synchronizer on KEY. Synchronizer reset value is 1 (released).
- Per key, a debounce counter of width clog2(DEBOUNCE_CYCLES)+1, plus a registered stable level.
  - Cycle where the synchronized value equals the stable level: counter clears to 0.
  - Cycle where it differs and counter == DEBOUNCE_CYCLES-1: stable level takes the new value, counter clears, and the matching pulse asserts for exactly that one cycle.
  - Otherwise, when it differs: counter increments.
- Latency: a clean raw transition first sampled at rising edge 1 changes pressed at edge DEBOUNCE_CYCLES+2. The pulse is registered and asserts in the same cycle pressed changes.
- Bounce: any return to the old level before the count completes clears the counter. Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no output activity.
- press_pulse and release_pulse for one key are never both high in one cycle. Different keys are fully independent; simultaneous events on several keys all pulse in the same cycle.
- Reset values: pressed = 0, press_pulse = 0, release_pulse = 0, any_press = 0, all counters 0, synchronizers 1.
- Reset mid-debounce discards the partial count. If a key is held through reset deassertion, it is treated as a new press: press_pulse arrives DEBOUNCE_CYCLES+2 edges after deassertion.
- No handshake: pulses are fire-and-forget; consumers must sample every cycle.

Optional Feature:
Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - Each key has a repeat counter, cleared on its accepted press.
  - While pressed stays 1, an extra press_pulse is emitted REPEAT_DELAY cycles after the initial press_pulse. Further pulses follow every REPEAT_PERIOD cycles after that.
  - Release clears the counter immediately. No repeat pulse may occur in or after the release_pulse cycle.
  - any_press includes repeats.
- Not defined: repeat counters are absent, REPEAT_* parameters are ignored, and there is exactly one press_pulse per accepted press.

Test Plan:
- DEBOUNCE_CYCLES=4; reset low 3 cycles, then high with KEY=11.
  -> all outputs 0 and no pulses for 20 cycles.
- Clean press: KEY[0] 1->0, first sampled at edge 1.
  -> pressed[0]=1 and press_pulse[0]=1 at edge 6; pulse lasts one cycle. Releasing the same way gives release_pulse[0] at the matching edge.
- Bounce: KEY[0] low for 3 cycles, high for 1, low for 3, then high.
  -> no pulse, pressed[0] remains 0.
- Both keys pressed on the same edge.
  -> press_pulse=11 and any_press=1 in the same single cycle.
- Key held and reset pulsed low mid-count (counter at 2).
  -> outputs 0 during reset; press_pulse[1] exactly 6 edges after deassertion.
- With KEY_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=3: hold KEY[0] for 30 cycles after the press pulse.
  -> repeat pulses at +10, +13, +16, ...; none after release. Without the macro: a single pulse.

Source files
------------

// File: rtl/key_conditioner_if.sv
// Key conditioner bus: raw active-low buttons in, conditioned levels and strobes out.
// Latency: none, this is wiring only.
// Backpressure: none; strobes are fire-and-forget, so consumers must sample every cycle.
interface key_conditioner_if #(
  parameter int N_KEYS = 2
);

  // Raw board buttons, active-low, asynchronous to the system clock.
  logic [N_KEYS-1:0] KEY;
  // Debounced level per key, 1 = pressed.
  logic [N_KEYS-1:0] pressed;
  // One-cycle strobe per accepted press, plus auto-repeats when they are built in.
  logic [N_KEYS-1:0] press_pulse;
  // One-cycle strobe per accepted release.
  logic [N_KEYS-1:0] release_pulse;
  // OR of press_pulse, in the same cycle.
  logic              any_press;

  // Button side: drives the raw keys and observes the conditioned outputs.
  modport master (
    output KEY,
    input  pressed,
    input  press_pulse,
    input  release_pulse,
    input  any_press
  );

  // Conditioner side: samples the raw keys and drives the conditioned outputs.
  modport slave (
    input  KEY,
    output pressed,
    output press_pulse,
    output release_pulse,
    output any_press
  );

endinterface

// File: rtl/key_conditioner.sv
// Debounces active-low push-buttons into clean levels plus press/release strobes; optional auto-repeat under KEY_AUTOREPEAT_EN.
// Latency: raw edge first sampled at edge 1 -> pressed and pulse change at edge DEBOUNCE_CYCLES+2.
// Backpressure: none; pulses are single-cycle and fire-and-forget.
module key_conditioner #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic               clock,
  input  logic               reset,
  key_conditioner_if.slave   kif
);

  // Enough width to hold DEBOUNCE_CYCLES-1 (stays at least 1 bit when DEBOUNCE_CYCLES is 1).
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

`ifdef KEY_AUTOREPEAT_EN
  // The repeat counter serves both the initial delay and the period, so size it for the larger one.
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX) + 1;
`endif

  // Reject illegal configurations at elaboration instead of building a broken counter.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
    $error("key_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  // Registered outputs, shared across all channels.
  logic [N_KEYS-1:0] level_q;
  logic [N_KEYS-1:0] level_d;
  logic [N_KEYS-1:0] press_q;
  logic [N_KEYS-1:0] press_d;
  logic [N_KEYS-1:0] release_q;
  logic [N_KEYS-1:0] release_d;
  logic              any_q;
  logic              any_d;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key

    // Synchronizer flops idle at 1, the released level of an active-low key.
    logic          sync1_q;
    logic          sync2_q;
    logic          sample_pressed;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          differ;
    logic          acc_press;
    logic          acc_release;
    logic          rep_fire;

    // Two-flop synchronizer for the asynchronous raw key.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= kif.KEY[k];
        sync2_q <= sync1_q;
      end
    end

    // Flip to active-high so the rest of the channel works in "pressed" terms.
    assign sample_pressed = ~sync2_q;
    assign differ         = (sample_pressed != level_q[k]);

    // Debounce: count consecutive differing samples, and accept the new level on the last one.
    always_comb begin
      cnt_d       = cnt_q;
      level_d[k]  = level_q[k];
      acc_press   = 1'b0;
      acc_release = 1'b0;
      if (!differ) begin
        // Any sample back at the stable level discards the partial count.
        cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_d       = '0;
        level_d[k]  = sample_pressed;
        acc_press   = sample_pressed;
        acc_release = ~sample_pressed;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Debounce counter register.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

`ifdef KEY_AUTOREPEAT_EN
    // rep_phase_q is 0 while the initial hold delay is running and 1 once the periodic repeats have begun.
    logic [RW-1:0] rep_cnt_q;
    logic [RW-1:0] rep_cnt_d;
    logic          rep_phase_q;
    logic          rep_phase_d;

    // Repeat timing, measured from the accepted press; a release in progress blocks any repeat in its own cycle.
    always_comb begin
      rep_cnt_d   = rep_cnt_q;
      rep_phase_d = rep_phase_q;
      rep_fire    = 1'b0;
      if (acc_press || acc_release || !level_q[k]) begin
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
      end else if ((!rep_phase_q && rep_cnt_q == RW'(REPEAT_DELAY - 1)) ||
                   ( rep_phase_q && rep_cnt_q == RW'(REPEAT_PERIOD - 1))) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = '0;
        rep_phase_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end

    // Repeat counter and phase registers.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rep_cnt_q   <= '0;
        rep_phase_q <= 1'b0;
      end else begin
        rep_cnt_q   <= rep_cnt_d;
        rep_phase_q <= rep_phase_d;
      end
    end
`else
    // Without auto-repeat, each accepted press yields exactly one press_pulse.
    assign rep_fire = 1'b0;
`endif

    assign press_d[k]   = acc_press | rep_fire;
    assign release_d[k] = acc_release;

  end : g_key

  assign any_d = |press_d;

  // Level and strobes are registered together, so each pulse lines up with its level change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
    end
  end

  assign kif.pressed       = level_q;
  assign kif.press_pulse   = press_q;
  assign kif.release_pulse = release_q;
  assign kif.any_press     = any_q;

endmodule
